// File: rtl/core_fetch.sv
// core_fetch: instruction fetch stage of the MCPC core.
// Issues one outstanding read per instruction at the PC supplied by the
// register file, pulses pc_inc when the read completes, and holds the
// fetched word for the decoder behind a valid/ready handshake. Handles
// flush (PC rewrite), halt and a sticky bus-timeout fault.
module core_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_in,
  input  logic        flush,
  input  logic        halt,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        pc_inc,
  output logic [15:0] instr_out,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_DROP  = 3'd2,
    S_FULL  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  // Timeout limit widened by one bit so the incremented counter never
  // aliases; a zero limit disables the check entirely.
  localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT_CYCLES);
  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_mem_addr;
  logic [15:0] r_instr_out;
  logic [15:0] r_instr_pc;
  logic [15:0] r_wait_cnt;

  logic        w_load_addr;
  logic        w_capture;
  logic        w_cnt_clr;
  logic        w_cnt_inc;
  logic        w_pc_inc;
  logic        w_timeout;
  logic [16:0] w_cnt_plus1;

  assign w_cnt_plus1 = {1'b0, r_wait_cnt} + 17'd1;

  // Next-state and per-cycle control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load_addr = 1'b0;
    w_capture   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_pc_inc    = 1'b0;
    w_timeout   = TO_EN && (w_cnt_plus1 == TO_LIMIT);

    case (r_state)
      S_IDLE: begin
        if (!halt) begin
          w_load_addr = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end

      S_REQ: begin
        if (mem_ack) begin
          if (!flush) begin
            w_capture   = 1'b1;
            w_pc_inc    = 1'b1;
            w_state_nxt = S_FULL;
          end else begin
            // Data arrived for a PC that is being overwritten: drop it.
            w_state_nxt = S_IDLE;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_FAULT;
        end else if (flush) begin
          // The request cannot be withdrawn; wait out its ack in DROP.
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_DROP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end

      S_DROP: begin
        if (mem_ack) begin
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end

      S_FULL: begin
        // Flush has priority over a decoder accept.
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (instr_ready) begin
          if (halt) begin
            w_state_nxt = S_IDLE;
          end else begin
            // pc_in already carries the increment issued when we left REQ.
            w_load_addr = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
      end

      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any outstanding request immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Wait counter for the outstanding read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 16'd0;
    end else if (w_cnt_clr) begin
      r_wait_cnt <= 16'd0;
    end else if (w_cnt_inc) begin
      r_wait_cnt <= w_cnt_plus1[15:0];
    end
  end

  // Request address: changes only when a new request is about to start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr <= 16'd0;
    end else if (w_load_addr) begin
      r_mem_addr <= pc_in;
    end
  end

  // Instruction buffer and its fetch address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_out <= 16'd0;
      r_instr_pc  <= 16'd0;
    end else if (w_capture) begin
      r_instr_out <= mem_rdata;
      r_instr_pc  <= r_mem_addr;
    end
  end

  assign mem_req     = (r_state == S_REQ) || (r_state == S_DROP);
  assign mem_addr    = r_mem_addr;
  assign pc_inc      = w_pc_inc;
  assign instr_out   = r_instr_out;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = (r_state == S_FULL);
  assign fault       = (r_state == S_FAULT);

endmodule

// File: tb/tb_core_fetch.sv
// Directed bench for core_fetch: a per-cycle vector table with
// hand-computed outputs, then a zero-wait streaming sequence across the
// 16-bit PC wrap.
module tb_core_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc_in = 16'h0000;
  logic        flush = 1'b0;
  logic        halt = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        pc_inc;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        fault;

  int n_vec  = 0;
  int n_fail = 0;

  core_fetch #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .flush      (flush),
    .halt       (halt),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .pc_inc     (pc_inc),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] pc;
    logic        fl;
    logic        ht;
    logic        ack;
    logic [15:0] rd;
    logic        rdy;
    logic        chk;
    logic        req;
    logic [15:0] addr;
    logic        inc;
    logic        vld;
    logic [15:0] iout;
    logic [15:0] ipc;
    logic        flt;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic [15:0] pc, input logic fl,
                     input logic ht, input logic ack, input logic [15:0] rd,
                     input logic rdy, input logic chk, input logic req,
                     input logic [15:0] addr, input logic inc, input logic vld,
                     input logic [15:0] iout, input logic [15:0] ipc,
                     input logic flt);
    vec_t v;
    v.rst = r;  v.pc = pc;    v.fl = fl;   v.ht = ht;    v.ack = ack;
    v.rd = rd;  v.rdy = rdy;  v.chk = chk; v.req = req;  v.addr = addr;
    v.inc = inc; v.vld = vld; v.iout = iout; v.ipc = ipc; v.flt = flt;
    vt.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic req,
                           input logic [15:0] addr, input logic inc,
                           input logic vld, input logic [15:0] iout,
                           input logic [15:0] ipc, input logic flt);
    n_vec++;
    check({tag, " mem_req"},     {15'd0, mem_req},     {15'd0, req});
    check({tag, " mem_addr"},    mem_addr,             addr);
    check({tag, " pc_inc"},      {15'd0, pc_inc},      {15'd0, inc});
    check({tag, " instr_valid"}, {15'd0, instr_valid}, {15'd0, vld});
    check({tag, " instr_out"},   instr_out,            iout);
    check({tag, " instr_pc"},    instr_pc,             ipc);
    check({tag, " fault"},       {15'd0, fault},       {15'd0, flt});
  endtask

  initial begin
    logic [15:0] pcm;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;

    //   rst pc      fl ht ack rd      rdy chk req addr   inc vld iout    ipc    flt
    // reset, then zero-wait fetch at 0000
    add(1, 'h0000, 0, 0, 0, 'h0000, 0, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 0);
    add(1, 'h0000, 0, 0, 0, 'h0000, 0, 1, 0, 'h0000, 0, 0, 'h0000, 'h0000, 0);
    add(0, 'h0000, 0, 0, 0, 'h0000, 1, 1, 0, 'h0000, 0, 0, 'h0000, 'h0000, 0);
    add(0, 'h0000, 0, 0, 1, 'h1234, 1, 1, 1, 'h0000, 1, 0, 'h0000, 'h0000, 0);
    add(0, 'h0001, 0, 0, 0, 'h0000, 1, 1, 0, 'h0000, 0, 1, 'h1234, 'h0000, 0);
    // 3-cycle ack latency, decoder stalls
    add(0, 'h0001, 0, 0, 0, 'h0000, 0, 1, 1, 'h0001, 0, 0, 'h1234, 'h0000, 0);
    add(0, 'h0001, 0, 0, 0, 'h0000, 0, 1, 1, 'h0001, 0, 0, 'h1234, 'h0000, 0);
    add(0, 'h0001, 0, 0, 0, 'h0000, 0, 1, 1, 'h0001, 0, 0, 'h1234, 'h0000, 0);
    add(0, 'h0001, 0, 0, 1, 'hABCD, 0, 1, 1, 'h0001, 1, 0, 'h1234, 'h0000, 0);
    add(0, 'h0002, 0, 0, 0, 'h0000, 0, 1, 0, 'h0001, 0, 1, 'hABCD, 'h0001, 0);
    add(0, 'h0002, 0, 0, 0, 'h0000, 0, 1, 0, 'h0001, 0, 1, 'hABCD, 'h0001, 0);
    add(0, 'h0002, 0, 0, 0, 'h0000, 0, 1, 0, 'h0001, 0, 1, 'hABCD, 'h0001, 0);
    add(0, 'h0002, 0, 0, 0, 'h0000, 1, 1, 0, 'h0001, 0, 1, 'hABCD, 'h0001, 0);
    // flush during pending request -> DROP, late ack discarded, refetch 0040
    add(0, 'h0002, 0, 0, 0, 'h0000, 0, 1, 1, 'h0002, 0, 0, 'hABCD, 'h0001, 0);
    add(0, 'h0002, 1, 0, 0, 'h0000, 0, 1, 1, 'h0002, 0, 0, 'hABCD, 'h0001, 0);
    add(0, 'h0040, 1, 0, 0, 'h0000, 0, 1, 1, 'h0002, 0, 0, 'hABCD, 'h0001, 0);
    add(0, 'h0040, 0, 0, 1, 'hDEAD, 0, 1, 1, 'h0002, 0, 0, 'hABCD, 'h0001, 0);
    add(0, 'h0040, 0, 0, 0, 'h0000, 0, 1, 0, 'h0002, 0, 0, 'hABCD, 'h0001, 0);
    add(0, 'h0040, 0, 0, 1, 'h5555, 0, 1, 1, 'h0040, 1, 0, 'hABCD, 'h0001, 0);
    // flush and ready together in FULL: flush wins, refetch 0080
    add(0, 'h0041, 1, 0, 0, 'h0000, 1, 1, 0, 'h0040, 0, 1, 'h5555, 'h0040, 0);
    add(0, 'h0080, 0, 0, 0, 'h0000, 0, 1, 0, 'h0040, 0, 0, 'h5555, 'h0040, 0);
    add(0, 'h0080, 0, 0, 1, 'h7777, 0, 1, 1, 'h0080, 1, 0, 'h5555, 'h0040, 0);
    // halt at transfer -> IDLE while halted, then fetch 0081
    add(0, 'h0081, 0, 1, 0, 'h0000, 1, 1, 0, 'h0080, 0, 1, 'h7777, 'h0080, 0);
    add(0, 'h0081, 0, 1, 0, 'h0000, 0, 1, 0, 'h0080, 0, 0, 'h7777, 'h0080, 0);
    add(0, 'h0081, 0, 1, 0, 'h0000, 0, 1, 0, 'h0080, 0, 0, 'h7777, 'h0080, 0);
    add(0, 'h0081, 0, 0, 0, 'h0000, 0, 1, 0, 'h0080, 0, 0, 'h7777, 'h0080, 0);
    // no ack for 4 cycles -> FAULT, sticky until rst
    add(0, 'h0081, 0, 0, 0, 'h0000, 0, 1, 1, 'h0081, 0, 0, 'h7777, 'h0080, 0);
    add(0, 'h0081, 0, 0, 0, 'h0000, 0, 1, 1, 'h0081, 0, 0, 'h7777, 'h0080, 0);
    add(0, 'h0081, 0, 0, 0, 'h0000, 0, 1, 1, 'h0081, 0, 0, 'h7777, 'h0080, 0);
    add(0, 'h0081, 0, 0, 0, 'h0000, 0, 1, 1, 'h0081, 0, 0, 'h7777, 'h0080, 0);
    add(0, 'h0081, 0, 0, 1, 'h0000, 1, 1, 0, 'h0081, 0, 0, 'h7777, 'h0080, 1);
    add(0, 'h0081, 1, 0, 0, 'h0000, 1, 1, 0, 'h0081, 0, 0, 'h7777, 'h0080, 1);
    add(1, 'h0000, 0, 0, 0, 'h0000, 0, 1, 0, 'h0081, 0, 0, 'h7777, 'h0080, 1);
    add(0, 'h0000, 0, 0, 0, 'h0000, 1, 1, 0, 'h0000, 0, 0, 'h0000, 'h0000, 0);
    add(0, 'h0000, 0, 0, 1, 'hF00D, 1, 1, 1, 'h0000, 1, 0, 'h0000, 'h0000, 0);
    // ack coinciding with flush: data dropped, no pc_inc, refetch 0020
    add(0, 'h0001, 0, 0, 0, 'h0000, 1, 1, 0, 'h0000, 0, 1, 'hF00D, 'h0000, 0);
    add(0, 'h0001, 1, 0, 1, 'h9999, 1, 1, 1, 'h0001, 0, 0, 'hF00D, 'h0000, 0);
    add(0, 'h0020, 0, 0, 0, 'h0000, 1, 1, 0, 'h0001, 0, 0, 'hF00D, 'h0000, 0);
    add(0, 'h0020, 0, 0, 0, 'h0000, 1, 1, 1, 'h0020, 0, 0, 'hF00D, 'h0000, 0);

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      rst         = vt[i].rst;
      pc_in       = vt[i].pc;
      flush       = vt[i].fl;
      halt        = vt[i].ht;
      mem_ack     = vt[i].ack;
      mem_rdata   = vt[i].rd;
      instr_ready = vt[i].rdy;
      #1;
      if (vt[i].chk) begin
        check_all($sformatf("vec%0d", i), vt[i].req, vt[i].addr, vt[i].inc,
                  vt[i].vld, vt[i].iout, vt[i].ipc, vt[i].flt);
      end
    end

    // Zero-wait streaming from FFFE across the PC wrap: REQ/FULL alternate.
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; halt = 1'b0;
    mem_ack = 1'b1; instr_ready = 1'b1; pc_in = 16'hFFFE;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("stream idle", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    pcm      = 16'hFFFE;
    exp_addr = 16'hFFFE;
    exp_data = 16'h0000;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      pc_in     = pcm;
      mem_rdata = 16'hA000 + 16'(k);
      #1;
      if (k % 2 == 1) begin
        check_all($sformatf("stream%0d req", k), 1'b1, exp_addr, 1'b1, 1'b0,
                  exp_data, (k == 1) ? 16'h0000 : exp_addr - 16'd1, 1'b0);
        exp_data = 16'hA000 + 16'(k);
        pcm      = pcm + 16'd1;
      end else begin
        check_all($sformatf("stream%0d full", k), 1'b0, exp_addr, 1'b0, 1'b1,
                  exp_data, exp_addr, 1'b0);
        exp_addr = exp_addr + 16'd1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
